// File: rtl/sensor_conditioner.sv
// Loop-detector conditioner: synchronizes the raw loop level, debounces arrival and
// departure, extends presence with a hold-over, flags a stuck loop and counts arrivals.
module sensor_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned HOLD_CYCLES     = 100000000,
   parameter int unsigned STUCK_CYCLES    = 1500000000
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       raw_loop,
   input  logic       count_clr,
   output logic       sensor,
   output logic       fault,
   output logic [7:0] vehicle_count
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      QUAL_ON  = 3'd1,
      PRESENT  = 3'd2,
      QUAL_OFF = 3'd3,
      HOLD     = 3'd4,
      FAULT    = 3'd5
   } state_t;

   localparam logic [31:0] DEB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] STUCK_LAST = 32'(STUCK_CYCLES - 1);

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        sync_meta_q, sync_in_q;
   logic        sensor_q, sensor_d;
   logic        fault_q, fault_d;
   logic [7:0]  count_q, count_d;
   logic        arrive;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         sync_meta_q <= 1'b0;
         sync_in_q   <= 1'b0;
      end else begin
         sync_meta_q <= raw_loop;
         sync_in_q   <= sync_meta_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 32'd1;
      arrive  = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync_in_q) state_d = QUAL_ON;
         end
         QUAL_ON: begin
            if (!sync_in_q) state_d = IDLE;
            else if (cnt_q == DEB_LAST) begin
               state_d = PRESENT;
               arrive  = 1'b1;
            end
         end
         PRESENT: begin
            if (!sync_in_q) state_d = QUAL_OFF;
            else if (cnt_q == STUCK_LAST) state_d = FAULT;
         end
         QUAL_OFF: begin
            if (sync_in_q) state_d = PRESENT;
            else if (cnt_q == DEB_LAST) state_d = HOLD;
         end
         HOLD: begin
            // Re-occupation during hold-over is the same platoon, so no new arrival.
            if (sync_in_q) state_d = PRESENT;
            else if (cnt_q == HOLD_LAST) state_d = IDLE;
         end
         FAULT: begin
            if (sync_in_q) cnt_d = 32'd0;
            else if (cnt_q == DEB_LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) cnt_d = 32'd0;

      sensor_d = (state_d == PRESENT) || (state_d == QUAL_OFF) ||
                 (state_d == HOLD) || (state_d == FAULT);
      fault_d  = (state_d == FAULT);

      count_d = count_q;
      if (arrive && (count_q != 8'd255)) count_d = count_q + 8'd1;
      if (count_clr) count_d = 8'd0;
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q  <= IDLE;
         cnt_q    <= 32'd0;
         sensor_q <= 1'b0;
         fault_q  <= 1'b0;
         count_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sensor_q <= sensor_d;
         fault_q  <= fault_d;
         count_q  <= count_d;
      end
   end

   assign sensor        = sensor_q;
   assign fault         = fault_q;
   assign vehicle_count = count_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with short timing parameters;
// inputs change and outputs are sampled on the falling clock edge.
module tb_sensor_conditioner;

   logic       clk;
   logic       clear;
   logic       raw_loop;
   logic       count_clr;
   logic       sensor;
   logic       fault;
   logic [7:0] vehicle_count;

   int check_count = 0;
   int fail_count  = 0;

   sensor_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES(10),
      .STUCK_CYCLES(50)
   ) dut (
      .clk(clk),
      .clear(clear),
      .raw_loop(raw_loop),
      .count_clr(count_clr),
      .sensor(sensor),
      .fault(fault),
      .vehicle_count(vehicle_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic raw, input int edges);
      raw_loop = raw;
      repeat (edges) @(negedge clk);
   endtask

   // One full arrival from IDLE: qualifies after 7 edges, back in IDLE 17 edges after leaving.
   task automatic runArrival();
      applyStimulus(1'b1, 8);
      applyStimulus(1'b0, 18);
   endtask

   initial begin
      clear     = 1'b1;
      raw_loop  = 1'b0;
      count_clr = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_sensor", 32'(sensor), 32'd0);
      checkOutput("reset_fault", 32'(fault), 32'd0);
      checkOutput("reset_count", 32'(vehicle_count), 32'd0);
      clear = 1'b0;

      applyStimulus(1'b1, 3);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1);
         checkOutput("glitch_sensor", 32'(sensor), 32'd0);
      end
      checkOutput("glitch_count", 32'(vehicle_count), 32'd0);

      applyStimulus(1'b1, 6);
      checkOutput("arrive_before_edge7", 32'(sensor), 32'd0);
      applyStimulus(1'b1, 1);
      checkOutput("arrive_sensor", 32'(sensor), 32'd1);
      checkOutput("arrive_count", 32'(vehicle_count), 32'd1);
      checkOutput("arrive_fault", 32'(fault), 32'd0);

      applyStimulus(1'b0, 16);
      checkOutput("hold_last_cycle", 32'(sensor), 32'd1);
      applyStimulus(1'b0, 1);
      checkOutput("hold_expired", 32'(sensor), 32'd0);
      checkOutput("depart_count", 32'(vehicle_count), 32'd1);

      applyStimulus(1'b1, 7);
      checkOutput("second_arrive", 32'(sensor), 32'd1);
      checkOutput("second_count", 32'(vehicle_count), 32'd2);
      applyStimulus(1'b0, 9);
      checkOutput("in_hold_sensor", 32'(sensor), 32'd1);
      for (int i = 0; i < 52; i++) begin
         applyStimulus(1'b1, 1);
         checkOutput("retrigger_sensor", 32'(sensor), 32'd1);
      end
      checkOutput("retrigger_count", 32'(vehicle_count), 32'd2);
      checkOutput("stuck_not_yet", 32'(fault), 32'd0);
      applyStimulus(1'b1, 1);
      checkOutput("stuck_fault", 32'(fault), 32'd1);
      checkOutput("stuck_sensor", 32'(sensor), 32'd1);

      applyStimulus(1'b0, 5);
      checkOutput("fault_still_held", 32'(fault), 32'd1);
      checkOutput("fault_sensor_held", 32'(sensor), 32'd1);
      applyStimulus(1'b0, 1);
      checkOutput("fault_release", 32'(fault), 32'd0);
      checkOutput("fault_release_sensor", 32'(sensor), 32'd0);

      for (int i = 0; i < 253; i++) runArrival();
      checkOutput("count_255", 32'(vehicle_count), 32'd255);
      runArrival();
      checkOutput("count_saturate", 32'(vehicle_count), 32'd255);

      applyStimulus(1'b1, 6);
      count_clr = 1'b1;
      applyStimulus(1'b1, 1);
      count_clr = 1'b0;
      checkOutput("clr_overrides_inc", 32'(vehicle_count), 32'd0);
      checkOutput("clr_arrive_sensor", 32'(sensor), 32'd1);
      applyStimulus(1'b0, 18);

      runArrival();
      runArrival();
      applyStimulus(1'b1, 8);
      checkOutput("pre_reset_count", 32'(vehicle_count), 32'd3);
      checkOutput("pre_reset_sensor", 32'(sensor), 32'd1);
      #2 clear = 1'b1;
      #1;
      checkOutput("async_sensor", 32'(sensor), 32'd0);
      checkOutput("async_count", 32'(vehicle_count), 32'd0);
      checkOutput("async_fault", 32'(fault), 32'd0);
      @(negedge clk);
      clear = 1'b0;
      applyStimulus(1'b1, 6);
      checkOutput("restart_before_edge7", 32'(sensor), 32'd0);
      applyStimulus(1'b1, 1);
      checkOutput("restart_sensor", 32'(sensor), 32'd1);
      checkOutput("restart_count", 32'(vehicle_count), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule
